// File: rtl/div_sub_pkg.sv
// Shared definitions for the repeated-subtraction divider: default width and
// controller state encoding.
package div_sub_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_A = 3'd1;
   localparam logic [2:0] ST_LOAD_B = 3'd2;
   localparam logic [2:0] ST_ITER   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      LOAD_A = ST_LOAD_A,
      LOAD_B = ST_LOAD_B,
      ITER   = ST_ITER,
      DONE   = ST_DONE
   } state_e;

endpackage

// File: rtl/div_sub_datapath.sv
// Divider datapath: dividend/remainder (A), divisor (B) and quotient (Q)
// registers with the subtractor, A>=B comparator and B==0 detect.
module div_sub_datapath
   import div_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ld_a,
   input  logic             ld_b,
   input  logic             clr_q,
   input  logic             sub_en,
   output logic             a_ge_b,
   output logic             b_zero,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] q_q, q_d;

   // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      q_d = q_q;
      if (ld_a) begin
         a_d = data_in;
      end else if (sub_en) begin
         a_d = a_q - b_q;
      end
      if (ld_b) begin
         b_d = data_in;
      end
      if (clr_q) begin
         q_d = '0;
      end else if (sub_en) begin
         q_d = q_q + 1'b1;
      end
   end

   // NOTE: non-blocking assignments here so every register samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         q_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         q_q <= q_d;
      end
   end

   assign a_ge_b = (a_q >= b_q);
   assign b_zero = (b_q == '0);
   assign a_out  = a_q;
   assign q_out  = q_q;

endmodule

// File: rtl/div_by_subtraction.sv
// Sequential unsigned divider: start edge detector and controller FSM driving
// the subtract-and-count datapath. Operands arrive on data_in after start.
module div_by_subtraction
   import div_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             div_by_zero
);

   state_e state_q, state_d;
   logic   start_q;
   logic   dbz_q, dbz_d;
   logic   go;
   logic   ld_a, ld_b, clr_q, sub_en;
   logic   a_ge_b, b_zero;

   assign go = start & ~start_q;

   div_sub_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_in (data_in),
      .ld_a    (ld_a),
      .ld_b    (ld_b),
      .clr_q   (clr_q),
      .sub_en  (sub_en),
      .a_ge_b  (a_ge_b),
      .b_zero  (b_zero),
      .a_out   (remainder),
      .q_out   (quotient)
   );

   always_comb begin
      state_d = state_q;
      dbz_d   = dbz_q;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      clr_q   = 1'b0;
      sub_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) state_d = LOAD_A;
         end
         LOAD_A: begin
            ld_a    = 1'b1;
            state_d = LOAD_B;
         end
         LOAD_B: begin
            ld_b    = 1'b1;
            clr_q   = 1'b1;
            dbz_d   = 1'b0;
            state_d = ITER;
         end
         ITER: begin
            // Zero divisor must be tested first: A>=0 is always true.
            if (b_zero) begin
               dbz_d   = 1'b1;
               state_d = DONE;
            end else if (a_ge_b) begin
               sub_en = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (go) state_d = LOAD_A;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         dbz_q   <= dbz_d;
      end
   end

   assign done        = (state_q == DONE);
   assign busy        = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == ITER);
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_by_subtraction.sv
// Self-checking bench for div_by_subtraction: directed vector table, random
// operands against an arithmetic reference, reset abort and start-hold cases.
module tb_div_by_subtraction;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] data_in;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         done;
   logic         busy;
   logic         div_by_zero;

   int total = 0;
   int bad   = 0;

   div_by_subtraction #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .data_in     (data_in),
      .quotient    (quotient),
      .remainder   (remainder),
      .done        (done),
      .busy        (busy),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      logic         exp_dbz;
      int           exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // Drives one operation; lat = edges from go-sample edge to done, busy_n =
   // post-edge samples with busy high (including the go edge itself).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                         output int lat, output int busy_n, output bit timed_out);
      lat = 0;
      busy_n = 0;
      timed_out = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 if (busy) busy_n++;
      @(negedge clk);
      start = hold;
      data_in = a;
      @(posedge clk);
      lat++;
      #1 if (busy) busy_n++;
      @(negedge clk);
      data_in = b;
      @(posedge clk);
      lat++;
      #1 if (busy) busy_n++;
      @(negedge clk);
      data_in = W'($urandom);
      for (int i = 0; i < 70000; i++) begin
         @(posedge clk);
         lat++;
         #1;
         if (done) begin
            timed_out = 1'b0;
            break;
         end
         if (busy) busy_n++;
      end
   endtask

   // Reference: plain division, divide-by-zero yields quotient 0 and the dividend.
   task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit hold, input bit chk_busy);
      int lat, busy_n, exp_lat;
      bit to;
      logic [W-1:0] eq, er;
      logic edbz;
      edbz = (b == '0);
      eq = edbz ? '0 : a / b;
      er = edbz ? a : a % b;
      exp_lat = edbz ? 3 : 3 + int'(eq);
      run_op(a, b, hold, lat, busy_n, to);
      check({tag, " timeout"}, 32'(to), 32'd0);
      check({tag, " quotient"}, 32'(quotient), 32'(eq));
      check({tag, " remainder"}, 32'(remainder), 32'(er));
      check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      if (chk_busy) check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
   endtask

   vec_t vecs[$];

   initial begin
      int lat, busy_n;
      bit to;
      logic [W-1:0] a, b;

      // Busy spans 2 load cycles, Q subtract cycles and one terminating compare.
      vecs.push_back('{a: 16'd17,    b: 16'd5, exp_q: 16'd3,     exp_r: 16'd2, exp_dbz: 1'b0, exp_lat: 6});
      vecs.push_back('{a: 16'd20,    b: 16'd5, exp_q: 16'd4,     exp_r: 16'd0, exp_dbz: 1'b0, exp_lat: 7});
      vecs.push_back('{a: 16'd3,     b: 16'd7, exp_q: 16'd0,     exp_r: 16'd3, exp_dbz: 1'b0, exp_lat: 3});
      vecs.push_back('{a: 16'd9,     b: 16'd0, exp_q: 16'd0,     exp_r: 16'd9, exp_dbz: 1'b1, exp_lat: 3});
      vecs.push_back('{a: 16'd0,     b: 16'd5, exp_q: 16'd0,     exp_r: 16'd0, exp_dbz: 1'b0, exp_lat: 3});
      vecs.push_back('{a: 16'd5,     b: 16'd5, exp_q: 16'd1,     exp_r: 16'd0, exp_dbz: 1'b0, exp_lat: 4});
      vecs.push_back('{a: 16'd0,     b: 16'd0, exp_q: 16'd0,     exp_r: 16'd0, exp_dbz: 1'b1, exp_lat: 3});
      vecs.push_back('{a: 16'd65535, b: 16'd1, exp_q: 16'd65535, exp_r: 16'd0, exp_dbz: 1'b0, exp_lat: 65538});

      rst_n = 1'b0;
      start = 1'b0;
      data_in = '0;
      #1;
      check("reset quotient", 32'(quotient), 32'd0);
      check("reset remainder", 32'(remainder), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, 1'b0, lat, busy_n, to);
         check($sformatf("vec%0d timeout", i), 32'(to), 32'd0);
         check($sformatf("vec%0d quotient", i), 32'(quotient), 32'(vecs[i].exp_q));
         check($sformatf("vec%0d remainder", i), 32'(remainder), 32'(vecs[i].exp_r));
         check($sformatf("vec%0d div_by_zero", i), 32'(div_by_zero), 32'(vecs[i].exp_dbz));
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d busy_cycles", i), 32'(busy_n), 32'(vecs[i].exp_lat));
      end

      // Result registers must hold while idling in DONE.
      repeat (3) @(posedge clk);
      #1;
      check("hold done", 32'(done), 32'd1);
      check("hold quotient", 32'(quotient), 32'd65535);

      for (int i = 0; i < 20; i++) begin
         int qq, av;
         b = W'($urandom_range(0, 1500));
         if (b == '0) begin
            a = W'($urandom_range(0, 65535));
         end else begin
            qq = $urandom_range(0, 40);
            av = int'(b) * qq + $urandom_range(0, int'(b) - 1);
            a = (av > 65535) ? 16'hFFFF : W'(av);
         end
         run_and_check($sformatf("rnd%0d", i), a, b, 1'b0, 1'b1);
      end

      // Abort mid-ITER with an asynchronous reset.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      data_in = 16'd1000;
      @(negedge clk);
      data_in = 16'd1;
      repeat (10) @(negedge clk);
      check("pre-abort busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort quotient", 32'(quotient), 32'd0);
      check("abort remainder", 32'(remainder), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort div_by_zero", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post-abort idle done", 32'(done), 32'd0);
      check("post-abort idle busy", 32'(busy), 32'd0);

      // Start held high through DONE must not launch a second operation.
      run_and_check("held", 16'd100, 16'd7, 1'b1, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("held no-retrigger done", 32'(done), 32'd1);
      check("held no-retrigger busy", 32'(busy), 32'd0);
      check("held quotient kept", 32'(quotient), 32'd14);
      @(negedge clk);
      start = 1'b0;
      run_and_check("retoggle", 16'd50, 16'd6, 1'b0, 1'b1);
      // Back-to-back from DONE, switching into the divide-by-zero path.
      run_and_check("b2b_dbz", 16'd1234, 16'd0, 1'b0, 1'b1);
      run_and_check("b2b_after_dbz", 16'd12, 16'd4, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
